btn_pulser_array: RTL and testbench



---
 rtl/btn_pulser_array_if.sv | 27 ++
 rtl/btn_pulser_array.sv | 142 ++++++++++++++
 tb/tb_btn_pulser_array.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/btn_pulser_array_if.sv
// Button front-end bus: raw button and repeat-enable inputs toward the block,
// and the debounced level, press/repeat pulse and release pulse coming back.
interface btn_pulser_array_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] pulse_o;
    logic [N_CH-1:0] release_o;

    modport master (
        output btn_in,
        output repeat_en,
        input  level_o,
        input  pulse_o,
        input  release_o
    );

    modport slave (
        input  btn_in,
        input  repeat_en,
        output level_o,
        output pulse_o,
        output release_o
    );
endinterface

// File: rtl/btn_pulser_array.sv
// Multi-channel push-button front end: per channel a two-flop synchroniser,
// a debouncer, and a press/auto-repeat/release pulse FSM, all independent.
module btn_pulser_array #(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 3
) (
    input logic                clk,
    input logic                rst,
    btn_pulser_array_if.slave  bus
);
    localparam int CW    = $clog2(DEBOUNCE_CYC + 1);
    localparam int MAXR  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW    = $clog2(MAXR + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } state_t;

    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] pulse_vec;
    logic [N_CH-1:0] rel_vec;

    assign bus.level_o   = level_vec;
    assign bus.pulse_o   = pulse_vec;
    assign bus.release_o = rel_vec;

    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic [CW-1:0] cnt;
        logic          level;
        logic          rise;
        logic          fall;
        logic          debounce_done;
        state_t        state;
        state_t        state_next;
        logic [TW-1:0] timer;
        logic [TW-1:0] timer_next;
        logic          pulse_q;
        logic          pulse_next;
        logic          rel_q;
        logic          rel_next;

        // The FSM reacts on the same edge that flips the level, so the pulses
        // line up with the first cycle of the new debounced level.
        assign debounce_done = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
        assign rise          = debounce_done && sync2;
        assign fall          = debounce_done && !sync2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                sync1 <= bus.btn_in[i];
                sync2 <= sync1;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (debounce_done) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= ST_IDLE;
                timer   <= '0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_next;
                timer   <= timer_next;
                pulse_q <= pulse_next;
                rel_q   <= rel_next;
            end
        end

        // A release outranks any repeat pulse falling due on the same edge.
        always_comb begin
            state_next = state;
            timer_next = timer;
            pulse_next = 1'b0;
            rel_next   = 1'b0;
            if (fall) begin
                state_next = ST_IDLE;
                timer_next = '0;
                rel_next   = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state_next = ST_HELD;
                            timer_next = '0;
                            pulse_next = 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!bus.repeat_en[i]) begin
                            timer_next = '0;
                        end else if (timer == TW'(REPEAT_DELAY - 1)) begin
                            state_next = ST_REPEAT;
                            timer_next = '0;
                            pulse_next = 1'b1;
                        end else begin
                            timer_next = timer + TW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!bus.repeat_en[i]) begin
                            state_next = ST_HELD;
                            timer_next = '0;
                        end else if (timer == TW'(REPEAT_PERIOD - 1)) begin
                            timer_next = '0;
                            pulse_next = 1'b1;
                        end else begin
                            timer_next = timer + TW'(1);
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end
                endcase
            end
        end

        assign level_vec[i] = level;
        assign pulse_vec[i] = pulse_q;
        assign rel_vec[i]   = rel_q;
    end
endmodule

// File: tb/tb_btn_pulser_array.sv
// Self-checking bench for btn_pulser_array: table of per-cycle vectors built
// from the press/release timing rules, scoreboard queue, plus a reset sequence.
module tb_btn_pulser_array;
    localparam int N     = 2;
    localparam int NEVER = 1000;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;

    logic clk = 1'b0;
    logic rst;

    btn_pulser_array_if #(.N_CH(N)) bus ();

    btn_pulser_array #(
        .N_CH          (N),
        .DEBOUNCE_CYC  (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] btn;
        logic [1:0] ren;
        logic [1:0] lvl;
        logic [1:0] pls;
        logic [1:0] rel;
        int         scen;
        int         cyc;
    } vec_t;

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] pls;
        logic [1:0] rel;
        int         scen;
        int         cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic addReset(input int scen);
        vec_t v;
        v.rst  = 1'b0;
        v.btn  = 2'b00;
        v.ren  = 2'b00;
        v.lvl  = 2'b00;
        v.pls  = 2'b00;
        v.rel  = 2'b00;
        v.scen = scen;
        v.cyc  = -1;
        vecs.push_back(v);
    endtask

    // Inputs for cycle t are sampled on edge t; outputs are observed after it.
    task automatic addPress(input int scen, input int len, input int k0, input int r0,
                            input int k1, input int r1, input logic [1:0] ren);
        addReset(scen);
        for (int t = 0; t < len; t++) begin
            vec_t v;
            v.rst  = 1'b1;
            v.ren  = ren;
            v.scen = scen;
            v.cyc  = t;
            for (int c = 0; c < 2; c++) begin
                int k;
                int r;
                k = (c == 0) ? k0 : k1;
                r = (c == 0) ? r0 : r1;
                v.btn[c] = (t >= k) && (t < r);
                v.lvl[c] = (t >= k + DB + 1) && (t < r + DB + 1);
                v.rel[c] = (t == r + DB + 1);
                v.pls[c] = (t == k + DB + 1) ||
                           (ren[c] && (t >= k + DB + 1 + RD) && (t < r + DB + 1) &&
                            ((t - (k + DB + 1 + RD)) % RP == 0));
            end
            vecs.push_back(v);
        end
    endtask

    task automatic addBounce(input int scen);
        addReset(scen);
        for (int t = 0; t < 30; t++) begin
            vec_t v;
            v.rst    = 1'b1;
            v.ren    = 2'b00;
            v.scen   = scen;
            v.cyc    = t;
            v.btn    = 2'b00;
            v.btn[0] = (t < 20) ? (((t / 2) % 2) == 1) : 1'b1;
            v.lvl    = {1'b0, (t >= 23)};
            v.pls    = {1'b0, (t == 23)};
            v.rel    = 2'b00;
            vecs.push_back(v);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst           = v.rst;
        bus.btn_in    = v.btn;
        bus.repeat_en = v.ren;
        e.lvl  = v.lvl;
        e.pls  = v.pls;
        e.rel  = v.rel;
        e.scen = v.scen;
        e.cyc  = v.cyc;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got size=0 required size>0");
        end else begin
            e = sb.pop_front();
            if ({bus.level_o, bus.pulse_o, bus.release_o} !== {e.lvl, e.pls, e.rel}) begin
                errors++;
                $display("[TB] FAIL outputs scen=%0d cyc=%0d got lvl=%b pls=%b rel=%b required lvl=%b pls=%b rel=%b",
                         e.scen, e.cyc, bus.level_o, bus.pulse_o, bus.release_o, e.lvl, e.pls, e.rel);
            end
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] btn, input logic [1:0] lvl,
                                input logic [1:0] pls, input int cyc);
        vec_t v;
        v.rst  = r;
        v.btn  = btn;
        v.ren  = 2'b00;
        v.lvl  = lvl;
        v.pls  = pls;
        v.rel  = 2'b00;
        v.scen = 6;
        v.cyc  = cyc;
        return v;
    endfunction

    initial begin
        rst           = 1'b0;
        bus.btn_in    = '0;
        bus.repeat_en = '0;

        // 1 clean press, 3 auto-repeat then release, 4 release on a repeat edge,
        // 5 both channels with only ch0 repeating, 2 bounce, 6 prefix of reset-mid-hold.
        addPress(1, 20, 0, NEVER, NEVER, NEVER, 2'b00);
        addBounce(2);
        addPress(3, 35, 0, 21, NEVER, NEVER, 2'b01);
        addPress(4, 25, 0, 13, NEVER, NEVER, 2'b01);
        addPress(5, 25, 0, NEVER, 0, NEVER, 2'b01);
        addPress(6, 11, 0, NEVER, NEVER, NEVER, 2'b00);

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n]);
            checkOutput();
        end

        // Reset asserted mid-hold must clear outputs without waiting for an edge.
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.level_o, bus.pulse_o, bus.release_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got lvl=%b pls=%b rel=%b required all zero",
                     bus.level_o, bus.pulse_o, bus.release_o);
        end
        applyStimulus(mk(1'b0, 2'b01, 2'b00, 2'b00, 100));
        checkOutput();
        for (int e = 1; e <= 9; e++) begin
            applyStimulus(mk(1'b1, 2'b01, {1'b0, (e >= DB + 2)}, {1'b0, (e == DB + 2)}, 100 + e));
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
